// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: CSR addresses, op encoding, mstatus bit positions.
package csr_pkg;

   typedef enum logic [1:0] {
      CSR_NONE = 2'b00,
      CSR_RW   = 2'b01,
      CSR_RS   = 2'b10,
      CSR_RC   = 2'b11
   } csr_op_e;

   localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
   localparam logic [11:0] ADDR_MTVEC     = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
   localparam logic [11:0] ADDR_MEPC      = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
   localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
   localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
   localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/csr_if.sv
// CSR access bus between the decoder (master) and the CSR file (slave).
interface csr_if #(
   parameter int XLEN = 32
);
   import csr_pkg::*;

   logic            csr_valid;
   csr_op_e         csr_op;
   logic [11:0]     csr_addr;
   logic [XLEN-1:0] csr_wdata;
   logic [XLEN-1:0] csr_rdata;
   logic            csr_illegal;

   modport master (
      output csr_valid, csr_op, csr_addr, csr_wdata,
      input  csr_rdata, csr_illegal
   );

   modport slave (
      input  csr_valid, csr_op, csr_addr, csr_wdata,
      output csr_rdata, csr_illegal
   );

endinterface

// File: rtl/csr_counter.sv
// CNT_WIDTH-bit free-running counter with XLEN-wide half writes; a write wins over the increment.
module csr_counter #(
   parameter int XLEN      = 32,
   parameter int CNT_WIDTH = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            inc,
   input  logic            wr_lo,
   input  logic            wr_hi,
   input  logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] lo,
   output logic [XLEN-1:0] hi
);

   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] cnt_nxt;

   generate
      if (CNT_WIDTH > XLEN) begin : g_wide
         // NOTE: always_comb assigns a default first so no path leaves cnt_nxt unassigned (no latch).
         always_comb begin
            cnt_nxt = cnt + CNT_WIDTH'(inc);
            if (wr_lo) begin
               cnt_nxt = {cnt[CNT_WIDTH-1:XLEN], wdata};
            end else if (wr_hi) begin
               cnt_nxt = {wdata[CNT_WIDTH-XLEN-1:0], cnt[XLEN-1:0]};
            end
         end
         assign hi = XLEN'(cnt[CNT_WIDTH-1:XLEN]);
      end else begin : g_narrow
         logic unused_wr_hi;
         always_comb begin
            cnt_nxt = cnt + CNT_WIDTH'(inc);
            if (wr_lo) begin
               cnt_nxt = wdata[CNT_WIDTH-1:0];
            end
         end
         assign hi           = '0;
         assign unused_wr_hi = wr_hi;
      end
   endgenerate

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_nxt;
      end
   end

   assign lo = cnt[XLEN-1:0];

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap/mret sequencer. Define CSR_COUNTERS_EN to add mcycle/minstret.
module csr_unit
   import csr_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] MSTATUS_RST = 32'h0000_1800,
   parameter logic [XLEN-1:0] MTVEC_RST   = '0,
   parameter int              CNT_WIDTH   = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   csr_if.slave            csr,
   input  logic            trap_req,
   input  logic [XLEN-1:0] trap_cause,
   input  logic [XLEN-1:0] trap_pc,
   input  logic            mret_req,
   input  logic            instret,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc
);

   logic            mie;
   logic            mpie;
   logic [XLEN-1:0] mtvec;
   logic [XLEN-1:0] mepc;
   logic [XLEN-1:0] mcause;
   logic [XLEN-1:0] mscratch;

   logic [XLEN-1:0] rd_data;
   logic [XLEN-1:0] wr_data;
   logic            hit;
   logic            wr_en;
   logic [XLEN-1:0] vec_base;

`ifdef CSR_COUNTERS_EN
   logic [XLEN-1:0] mcycle_lo;
   logic [XLEN-1:0] mcycle_hi;
   logic [XLEN-1:0] minstret_lo;
   logic [XLEN-1:0] minstret_hi;

   csr_counter #(.XLEN(XLEN), .CNT_WIDTH(CNT_WIDTH)) u_mcycle (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (1'b1),
      .wr_lo (wr_en && csr.csr_addr == ADDR_MCYCLE),
      .wr_hi (wr_en && csr.csr_addr == ADDR_MCYCLEH),
      .wdata (wr_data),
      .lo    (mcycle_lo),
      .hi    (mcycle_hi)
   );

   csr_counter #(.XLEN(XLEN), .CNT_WIDTH(CNT_WIDTH)) u_minstret (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (instret),
      .wr_lo (wr_en && csr.csr_addr == ADDR_MINSTRET),
      .wr_hi (wr_en && csr.csr_addr == ADDR_MINSTRETH),
      .wdata (wr_data),
      .lo    (minstret_lo),
      .hi    (minstret_hi)
   );
`else
   logic unused_instret;
   assign unused_instret = instret;
`endif

   // Read mux: hit doubles as the legality decode for both reads and writes.
   always_comb begin
      rd_data = '0;
      hit     = 1'b0;
      case (csr.csr_addr)
         ADDR_MSTATUS: begin
            hit                                    = 1'b1;
            rd_data[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
            rd_data[MSTATUS_MPIE]                  = mpie;
            rd_data[MSTATUS_MIE]                   = mie;
         end
         ADDR_MTVEC:    begin hit = 1'b1; rd_data = mtvec;    end
         ADDR_MSCRATCH: begin hit = 1'b1; rd_data = mscratch; end
         ADDR_MEPC:     begin hit = 1'b1; rd_data = mepc;     end
         ADDR_MCAUSE:   begin hit = 1'b1; rd_data = mcause;   end
         ADDR_MCYCLE: begin
`ifdef CSR_COUNTERS_EN
            hit = 1'b1; rd_data = mcycle_lo;
`endif
         end
         ADDR_MCYCLEH: begin
`ifdef CSR_COUNTERS_EN
            hit = 1'b1; rd_data = mcycle_hi;
`endif
         end
         ADDR_MINSTRET: begin
`ifdef CSR_COUNTERS_EN
            hit = 1'b1; rd_data = minstret_lo;
`endif
         end
         ADDR_MINSTRETH: begin
`ifdef CSR_COUNTERS_EN
            hit = 1'b1; rd_data = minstret_hi;
`endif
         end
         default: ;
      endcase
   end

   always_comb begin
      wr_data = csr.csr_wdata;
      case (csr.csr_op)
         CSR_RS:  wr_data = rd_data | csr.csr_wdata;
         CSR_RC:  wr_data = rd_data & ~csr.csr_wdata;
         default: ;
      endcase
   end

   // Trap and mret both outrank a CSR write in the same cycle.
   assign wr_en = csr.csr_valid && (csr.csr_op != CSR_NONE) && hit && !trap_req && !mret_req;

   assign csr.csr_rdata   = rd_data;
   assign csr.csr_illegal = csr.csr_valid && !hit;

   assign vec_base       = {mtvec[XLEN-1:2], 2'b00};
   assign redirect_valid = trap_req || mret_req;

   always_comb begin
      redirect_pc = mepc;
      if (trap_req) begin
         if (mtvec[1:0] == 2'b01 && trap_cause[XLEN-1]) begin
            redirect_pc = vec_base + {trap_cause[XLEN-3:0], 2'b00};
         end else begin
            redirect_pc = vec_base;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mie      <= MSTATUS_RST[MSTATUS_MIE];
         mpie     <= MSTATUS_RST[MSTATUS_MPIE];
         mtvec    <= MTVEC_RST;
         mepc     <= '0;
         mcause   <= '0;
         mscratch <= '0;
      end else if (trap_req) begin
         mepc   <= trap_pc & ~XLEN'(3);
         mcause <= trap_cause;
         mpie   <= mie;
         mie    <= 1'b0;
      end else if (mret_req) begin
         mie  <= mpie;
         mpie <= 1'b1;
      end else if (wr_en) begin
         case (csr.csr_addr)
            ADDR_MSTATUS: begin
               mie  <= wr_data[MSTATUS_MIE];
               mpie <= wr_data[MSTATUS_MPIE];
            end
            ADDR_MTVEC:    mtvec    <= wr_data;
            ADDR_MSCRATCH: mscratch <= wr_data;
            ADDR_MEPC:     mepc     <= wr_data & ~XLEN'(3);
            ADDR_MCAUSE:   mcause   <= wr_data;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: directed vector table, counter/reset sequences, random run vs a reference model.
module tb_csr_unit;
   import csr_pkg::*;

`ifdef CSR_COUNTERS_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   typedef struct {
      logic        valid;
      logic [1:0]  op;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic        trap;
      logic [31:0] cause;
      logic [31:0] pc;
      logic        mret;
      logic        instr;
   } stim_t;

   typedef struct {
      stim_t       s;
      logic [31:0] rd;
      logic        ill;
      logic        rv;
      logic [31:0] rpc;
      bit          chk_rd;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        trap_req;
   logic [31:0] trap_cause;
   logic [31:0] trap_pc;
   logic        mret_req;
   logic        instret;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   csr_if #(.XLEN(32)) bus ();

   csr_unit #(.XLEN(32)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .csr            (bus),
      .trap_req       (trap_req),
      .trap_cause     (trap_cause),
      .trap_pc        (trap_pc),
      .mret_req       (mret_req),
      .instret        (instret),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_fail;

   // Reference model: architectural CSR values kept as whole words.
   logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_mscratch;
   logic [63:0] m_mcycle, m_minstret;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic stim_t mk(input logic valid, input logic [1:0] op, input logic [11:0] addr,
                                input logic [31:0] wdata, input logic trap, input logic [31:0] cause,
                                input logic [31:0] pc, input logic mret);
      stim_t s;
      s.valid = valid; s.op = op; s.addr = addr; s.wdata = wdata;
      s.trap = trap; s.cause = cause; s.pc = pc; s.mret = mret; s.instr = 1'b0;
      return s;
   endfunction

   task automatic add(input stim_t s, input logic [31:0] rd, input logic ill, input logic rv,
                      input logic [31:0] rpc, input bit chk_rd);
      vec_t v;
      v.s = s; v.rd = rd; v.ill = ill; v.rv = rv; v.rpc = rpc; v.chk_rd = chk_rd;
      vecs.push_back(v);
   endtask

   task automatic model_reset();
      m_mstatus = 32'h1800; m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_mscratch = 0;
      m_mcycle = 0; m_minstret = 0;
   endtask

   function automatic logic [31:0] m_read(input logic [11:0] a, output bit legal);
      logic [31:0] r = 0;
      legal = 1'b1;
      case (a)
         12'h300: r = m_mstatus;
         12'h305: r = m_mtvec;
         12'h340: r = m_mscratch;
         12'h341: r = m_mepc;
         12'h342: r = m_mcause;
         12'hB00: begin legal = CNT_EN; if (CNT_EN) r = m_mcycle[31:0];    end
         12'hB80: begin legal = CNT_EN; if (CNT_EN) r = m_mcycle[63:32];   end
         12'hB02: begin legal = CNT_EN; if (CNT_EN) r = m_minstret[31:0];  end
         12'hB82: begin legal = CNT_EN; if (CNT_EN) r = m_minstret[63:32]; end
         default: legal = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] m_target(input stim_t s);
      logic [31:0] base = m_mtvec & ~32'h3;
      if (s.trap) begin
         if (m_mtvec[1:0] == 2'b01 && s.cause[31]) return base + (s.cause & 32'h7FFF_FFFF) * 4;
         return base;
      end
      return m_mepc;
   endfunction

   task automatic model_step(input stim_t s);
      bit legal, wr_cyc, wr_ins;
      logic [31:0] old, nv;
      wr_cyc = 0; wr_ins = 0;
      old = m_read(s.addr, legal);
      if (s.trap) begin
         m_mepc    = s.pc & ~32'h3;
         m_mcause  = s.cause;
         m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
      end else if (s.mret) begin
         m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
      end else if (s.valid && s.op != 2'b00 && legal) begin
         if (s.op == 2'b01)      nv = s.wdata;
         else if (s.op == 2'b10) nv = old | s.wdata;
         else                    nv = old & ~s.wdata;
         case (s.addr)
            12'h300: m_mstatus  = 32'h1800 | (nv & 32'h88);
            12'h305: m_mtvec    = nv;
            12'h340: m_mscratch = nv;
            12'h341: m_mepc     = nv & ~32'h3;
            12'h342: m_mcause   = nv;
            12'hB00: begin m_mcycle[31:0]    = nv; wr_cyc = 1; end
            12'hB80: begin m_mcycle[63:32]   = nv; wr_cyc = 1; end
            12'hB02: begin m_minstret[31:0]  = nv; wr_ins = 1; end
            12'hB82: begin m_minstret[63:32] = nv; wr_ins = 1; end
            default: ;
         endcase
      end
      if (!wr_cyc) m_mcycle = m_mcycle + 64'd1;
      if (!wr_ins && s.instr) m_minstret = m_minstret + 64'd1;
   endtask

   task automatic drive(input stim_t s);
      bus.csr_valid = s.valid;
      bus.csr_op    = csr_op_e'(s.op);
      bus.csr_addr  = s.addr;
      bus.csr_wdata = s.wdata;
      trap_req      = s.trap;
      trap_cause    = s.cause;
      trap_pc       = s.pc;
      mret_req      = s.mret;
      instret       = s.instr;
   endtask

   // Entered and left at a falling edge; exactly one rising edge per call.
   task automatic tick(input stim_t s, output logic [31:0] rd, output logic ill,
                       output logic rv, output logic [31:0] rpc);
      bit legal;
      logic [31:0] e_rd;
      drive(s);
      #1;
      rd = bus.csr_rdata; ill = bus.csr_illegal; rv = redirect_valid; rpc = redirect_pc;
      e_rd = m_read(s.addr, legal);
      check("model_rdata", rd, e_rd);
      check("model_illegal", ill, s.valid && !legal);
      check("model_redirect_valid", rv, s.trap || s.mret);
      if (s.trap || s.mret) check("model_redirect_pc", rpc, m_target(s));
      @(posedge clk);
      model_step(s);
      @(negedge clk);
   endtask

   function automatic stim_t rand_stim();
      logic [11:0] addrs[11] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
                                 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h123, 12'h7C0};
      stim_t s;
      s.valid = ($urandom_range(0, 9) < 7);
      s.op    = 2'($urandom_range(0, 3));
      s.addr  = addrs[$urandom_range(0, 10)];
      s.wdata = $urandom;
      s.trap  = ($urandom_range(0, 15) == 0);
      s.cause = ($urandom_range(0, 1) == 1) ? (32'h8000_0000 | 32'($urandom_range(0, 15)))
                                            : 32'($urandom_range(0, 15));
      s.pc    = $urandom;
      s.mret  = ($urandom_range(0, 15) == 0);
      s.instr = 1'($urandom_range(0, 1));
      return s;
   endfunction

   task automatic mid_reset();
      drive(mk(1'b1, 2'b01, 12'h340, 32'hA5A5_A5A5, 1'b0, 0, 0, 1'b0));
      #2 rst_n = 1'b0;
      #1 model_reset();
      check("rst_async_mscratch", bus.csr_rdata, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] rd, rpc, hi0;
      logic ill, rv;
      stim_t idle;
      n_checks = 0;
      n_fail   = 0;
      idle     = mk(1'b0, 2'b00, 12'h000, 0, 1'b0, 0, 0, 1'b0);
      rst_n    = 1'b0;
      drive(idle);
      model_reset();

      // Reset state, sampled while reset is held.
      #2 bus.csr_addr = 12'h300;
      #1 check("rst_mstatus", bus.csr_rdata, 32'h1800);
      bus.csr_addr = 12'h305;
      #1 check("rst_mtvec", bus.csr_rdata, 32'h0);
      check("rst_redirect_valid", redirect_valid, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table: expected values hand-derived from the CSR rules.
      add(mk(1, 2'b00, 12'h300, 0, 0, 0, 0, 0), 32'h1800, 0, 0, 0, 1);
      add(mk(1, 2'b00, 12'h305, 0, 0, 0, 0, 0), 32'h0, 0, 0, 0, 1);
      add(mk(1, 2'b00, 12'h341, 0, 0, 0, 0, 0), 32'h0, 0, 0, 0, 1);
      add(mk(1, 2'b00, 12'h342, 0, 0, 0, 0, 0), 32'h0, 0, 0, 0, 1);
      add(mk(1, 2'b01, 12'h340, 32'hF0F0_0000, 0, 0, 0, 0), 32'h0, 0, 0, 0, 1);
      add(mk(1, 2'b10, 12'h340, 32'h0000_00FF, 0, 0, 0, 0), 32'hF0F0_0000, 0, 0, 0, 1);
      add(mk(1, 2'b11, 12'h340, 32'hF000_0000, 0, 0, 0, 0), 32'hF0F0_00FF, 0, 0, 0, 1);
      add(mk(1, 2'b00, 12'h340, 0, 0, 0, 0, 0), 32'h00F0_00FF, 0, 0, 0, 1);
      add(mk(1, 2'b01, 12'h305, 32'h8000_0100, 0, 0, 0, 0), 32'h0, 0, 0, 0, 1);
      add(mk(1, 2'b10, 12'h300, 32'h8, 0, 0, 0, 0), 32'h1800, 0, 0, 0, 1);
      add(mk(1, 2'b00, 12'h300, 0, 1, 32'd11, 32'h8000_0042, 0), 32'h1808, 0, 1, 32'h8000_0100, 1);
      add(mk(1, 2'b00, 12'h341, 0, 0, 0, 0, 0), 32'h8000_0040, 0, 0, 0, 1);
      add(mk(1, 2'b00, 12'h342, 0, 0, 0, 0, 0), 32'd11, 0, 0, 0, 1);
      add(mk(1, 2'b00, 12'h300, 0, 0, 0, 0, 0), 32'h1880, 0, 0, 0, 1);
      add(mk(1, 2'b00, 12'h300, 0, 0, 0, 0, 1), 32'h1880, 0, 1, 32'h8000_0040, 1);
      add(mk(1, 2'b00, 12'h300, 0, 0, 0, 0, 0), 32'h1888, 0, 0, 0, 1);
      add(mk(1, 2'b01, 12'h341, 32'hDEAD_BEEF, 1, 32'd2, 32'h0000_1237, 1), 32'h8000_0040, 0, 1, 32'h8000_0100, 1);
      add(mk(1, 2'b00, 12'h341, 0, 0, 0, 0, 0), 32'h0000_1234, 0, 0, 0, 1);
      add(mk(1, 2'b00, 12'h342, 0, 0, 0, 0, 0), 32'd2, 0, 0, 0, 1);
      add(mk(1, 2'b00, 12'h300, 0, 0, 0, 0, 0), 32'h1880, 0, 0, 0, 1);
      add(mk(1, 2'b01, 12'h300, 32'hFFFF_FFFF, 0, 0, 0, 0), 32'h1880, 0, 0, 0, 1);
      add(mk(1, 2'b00, 12'h300, 0, 0, 0, 0, 0), 32'h1888, 0, 0, 0, 1);
      add(mk(1, 2'b01, 12'h341, 32'hFFFF_FFFF, 0, 0, 0, 0), 32'h0000_1234, 0, 0, 0, 1);
      add(mk(1, 2'b00, 12'h341, 0, 0, 0, 0, 0), 32'hFFFF_FFFC, 0, 0, 0, 1);
      add(mk(1, 2'b01, 12'h305, 32'h8000_0101, 0, 0, 0, 0), 32'h8000_0100, 0, 0, 0, 1);
      add(mk(1, 2'b00, 12'h305, 0, 1, 32'h8000_0003, 32'h100, 0), 32'h8000_0101, 0, 1, 32'h8000_010C, 1);
      add(mk(1, 2'b00, 12'h342, 0, 0, 0, 0, 0), 32'h8000_0003, 0, 0, 0, 1);
      add(mk(1, 2'b00, 12'h305, 0, 1, 32'd3, 32'h200, 0), 32'h8000_0101, 0, 1, 32'h8000_0100, 1);
      add(mk(1, 2'b00, 12'h123, 0, 0, 0, 0, 0), 32'h0, 1, 0, 0, 1);
      add(mk(1, 2'b01, 12'h7C0, 32'h1234_5678, 0, 0, 0, 0), 32'h0, 1, 0, 0, 1);
      add(mk(1, 2'b00, 12'hB00, 0, 0, 0, 0, 0), 32'h0, !CNT_EN, 0, 0, !CNT_EN);
      add(mk(0, 2'b00, 12'h123, 0, 0, 0, 0, 0), 32'h0, 0, 0, 0, 1);
      add(mk(1, 2'b00, 12'h341, 0, 0, 0, 0, 1), 32'h200, 0, 1, 32'h200, 1);
      add(mk(1, 2'b00, 12'h300, 0, 0, 0, 0, 0), 32'h1880, 0, 0, 0, 1);

      foreach (vecs[i]) begin
         tick(vecs[i].s, rd, ill, rv, rpc);
         if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, vecs[i].rd);
         check($sformatf("vec%0d_illegal", i), ill, vecs[i].ill);
         check($sformatf("vec%0d_redirect_valid", i), rv, vecs[i].rv);
         if (vecs[i].rv) check($sformatf("vec%0d_redirect_pc", i), rpc, vecs[i].rpc);
      end

`ifdef CSR_COUNTERS_EN
      // mcycle low-half wrap carries into mcycleh.
      hi0 = m_mcycle[63:32];
      tick(mk(1, 2'b01, 12'hB00, 32'hFFFF_FFFF, 0, 0, 0, 0), rd, ill, rv, rpc);
      tick(mk(1, 2'b00, 12'hB00, 0, 0, 0, 0, 0), rd, ill, rv, rpc);
      check("mcycle_lo_written", rd, 32'hFFFF_FFFF);
      tick(mk(1, 2'b00, 12'hB00, 0, 0, 0, 0, 0), rd, ill, rv, rpc);
      check("mcycle_lo_wrapped", rd, 32'h0);
      tick(mk(1, 2'b00, 12'hB80, 0, 0, 0, 0, 0), rd, ill, rv, rpc);
      check("mcycleh_carry", rd, hi0 + 32'd1);
      tick(mk(1, 2'b01, 12'hB82, 32'h5, 0, 0, 0, 0), rd, ill, rv, rpc);
      tick(mk(1, 2'b00, 12'hB82, 0, 0, 0, 0, 0), rd, ill, rv, rpc);
      check("minstreth_written", rd, 32'h5);
`else
      hi0 = 32'h0;
      tick(mk(1, 2'b00, 12'hB80, 0, 0, 0, 0, 0), rd, ill, rv, rpc);
      check("mcycleh_absent_illegal", ill, 1'b1);
      check("mcycleh_absent_rdata", rd, hi0);
`endif

      // Reset in the middle of a write drops it.
      mid_reset();
      tick(mk(1, 2'b00, 12'h340, 0, 0, 0, 0, 0), rd, ill, rv, rpc);
      check("post_reset_mscratch", rd, 32'h0);

      for (int n = 0; n < 3000; n++) begin
         if (n % 700 == 699) mid_reset();
         tick(rand_stim(), rd, ill, rv, rpc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
